// File: rtl/trinity_pkg.sv
// trinity_pkg: shared constants, FSM state type and command record for the
// trinity_mem command sequencer.
//   BUS_VALID_BIT / BUS_EXEC_BIT : bit positions inside the tile bus word
//   MODE_WRITE                   : tile mode that writes memory
//   seq_state_e                  : sequencer FSM states
//   cmd_t                        : one buffered command (mode + data)
package trinity_pkg;

  localparam int          BUS_VALID_BIT = 7;
  localparam int          BUS_EXEC_BIT  = 2;
  localparam logic [1:0]  MODE_WRITE    = 2'd2;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} seq_state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
  } cmd_t;

  // Issue word: valid + exec set, mode in [1:0], everything else zero.
  function automatic logic [7:0] issue_word(input logic [1:0] mode);
    logic [7:0] w;
    w                = 8'h00;
    w[BUS_VALID_BIT] = 1'b1;
    w[BUS_EXEC_BIT]  = 1'b1;
    w[1:0]           = mode;
    return w;
  endfunction

endpackage

// File: rtl/trinity_cmd_fifo.sv
// trinity_cmd_fifo: synchronous FIFO of DEPTH command records.
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write request (ignored when full)
//   pop, dout     : read request (ignored when empty); dout shows the head
//   full, empty   : occupancy flags from pointer compare
//   level         : number of stored entries
module trinity_cmd_fifo
  import trinity_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing wrap
  // bits means full, identical pointers means empty.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trinity_bus_seq.sv
// trinity_bus_seq: buffers host commands, issues each one to the trinity_mem
// tile as a single-cycle exec pulse, and returns the tile result.
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   cmd_valid/ready/mode/data : host command port (valid/ready)
//   rsp_valid/ready/data/mode : response port (valid/ready)
//   tile_data, tile_bus       : drive tile data_in / bus_in
//   tile_result               : tile data_out
//   busy                      : FSM active or commands queued
module trinity_bus_seq
  import trinity_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_mode,
  output logic [7:0] tile_data,
  output logic [7:0] tile_bus,
  input  logic [7:0] tile_result,
  output logic       busy
);

  seq_state_e            state;
  cmd_t                  head;
  logic                  full, empty, pop;
  logic [$clog2(DEPTH):0] level;
  logic [1:0]            cur_mode;

  // Pop only from IDLE, so the response-handshake cycle (RESP) never pops.
  assign pop       = (state == IDLE) && !empty;
  assign cmd_ready = !full;
  assign busy      = (state != IDLE) || (level != '0);

  trinity_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (cmd_valid && cmd_ready),
    .din   ('{mode: cmd_mode, data: cmd_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      cur_mode  <= 2'd0;
      tile_data <= 8'h00;
      tile_bus  <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_mode  <= 2'd0;
    end else begin
      unique case (state)
        IDLE: if (!empty) begin
          tile_data <= head.data;
          tile_bus  <= issue_word(head.mode);
          cur_mode  <= head.mode;
          state     <= DRIVE;
        end
        // The tile samples the exec at the edge leaving DRIVE; dropping the
        // bus here guarantees exactly one exec per command.
        DRIVE: begin
          tile_bus <= 8'h00;
          state    <= WAIT;
        end
        WAIT: begin
          rsp_data  <= tile_result;
          rsp_mode  <= cur_mode;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trinity_bus_seq.sv
module tb_trinity_bus_seq;

  localparam int DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_mode;
  logic [7:0] tile_data;
  logic [7:0] tile_bus;
  logic [7:0] tile_result;
  logic       busy;

  always #5 sys_clk = ~sys_clk;

  trinity_bus_seq #(.DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_mode    (rsp_mode),
    .tile_data   (tile_data),
    .tile_bus    (tile_bus),
    .tile_result (tile_result),
    .busy        (busy)
  );

  // Behavioural stand-in for the trinity_mem tile (memory never reset).
  logic [7:0] tmem [8];
  initial begin
    for (int i = 0; i < 8; i++) tmem[i] = 8'h00;
    tile_result = 8'h00;
  end
  always @(posedge sys_clk) begin
    if (tile_bus[7] && tile_bus[2]) begin
      if (tile_bus[1:0] == 2'd2) begin
        tile_result         <= tmem[tile_data[2:0]];
        tmem[tile_data[2:0]] <= tile_data;
      end else begin
        tile_result <= tile_data;
      end
    end
  end

  // Reference model and scoreboard queues.
  logic [7:0] ref_mem [8];
  logic [9:0] exp_q[$];   // {mode, result}
  logic [9:0] iss_q[$];   // {mode, data} in issue order
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [1:0] m, input logic [7:0] d);
    logic [7:0] r;
    if (m == 2'd2) begin
      r = ref_mem[d[2:0]];
      ref_mem[d[2:0]] = d;
    end else begin
      r = d;
    end
    exp_q.push_back({m, r});
    iss_q.push_back({m, d});
  endtask

  // Monitors: every nonzero bus word is one issued command; every
  // valid&ready response is one completed command.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (tile_bus != 8'h00) begin
        if (iss_q.size() == 0) begin
          check("unexpected_exec", {8'h00, tile_bus}, 16'h0000);
        end else begin
          logic [9:0] e;
          e = iss_q.pop_front();
          check("bus_word", {8'h00, tile_bus}, {8'h00, 6'b100001, e[9:8]});
          check("tile_data", {8'h00, tile_data}, {8'h00, e[7:0]});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {6'h00, rsp_mode, rsp_data}, 16'hffff);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("rsp_data", {8'h00, rsp_data}, {8'h00, e[7:0]});
          check("rsp_mode", {14'h0, rsp_mode}, {14'h0, e[9:8]});
        end
      end
    end
  end

  // rsp_ready driver: fixed level or random per cycle.
  bit   rr_rand  = 1'b0;
  logic rr_fixed = 1'b1;
  initial rsp_ready = 1'b1;
  always @(posedge sys_clk) begin
    #1;
    rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  end

  task automatic push_cmd(input logic [1:0] m, input logic [7:0] d);
    int  t = 0;
    bit  done = 0;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!done && t < 200) begin
      @(negedge sys_clk);
      if (cmd_ready) begin
        model_push(m, d);
        done = 1;
      end
      @(posedge sys_clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    if (!done) check("push_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(posedge sys_clk);
      t++;
    end
    #1;
    check("drain", {15'h0, (exp_q.size() == 0 && !busy)}, 16'd1);
  endtask

  initial begin
    int  acc;
    bit  seen;
    bit  stray;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_data  = 8'h00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_cmd_ready", {15'h0, cmd_ready}, 16'd1);
    check("rst_rsp_valid", {15'h0, rsp_valid}, 16'd0);
    check("rst_rsp_data",  {8'h0, rsp_data},   16'd0);
    check("rst_rsp_mode",  {14'h0, rsp_mode},  16'd0);
    check("rst_tile_data", {8'h0, tile_data},  16'd0);
    check("rst_tile_bus",  {8'h0, tile_bus},   16'd0);
    check("rst_busy",      {15'h0, busy},      16'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // Single echo command: latency and one-cycle exec.
    push_cmd(2'd0, 8'h5A);                 // returns just after E0
    @(negedge sys_clk);
    check("e0_bus", {8'h0, tile_bus}, 16'h00);
    @(negedge sys_clk);                    // after E1
    check("e1_bus", {8'h0, tile_bus}, 16'h84);
    @(negedge sys_clk);                    // after E2
    check("e2_bus", {8'h0, tile_bus}, 16'h00);
    check("e2_rsp_valid", {15'h0, rsp_valid}, 16'd0);
    @(negedge sys_clk);                    // after E3
    check("e3_rsp_valid", {15'h0, rsp_valid}, 16'd1);
    check("e3_rsp_data", {8'h0, rsp_data}, 16'h5A);
    wait_drain();

    // Writes to address 3 and read-back of old contents.
    push_cmd(2'd2, 8'h0B);
    push_cmd(2'd2, 8'h13);
    push_cmd(2'd2, 8'h0B);
    wait_drain();

    // Stalled response: DEPTH in FIFO plus one in the FSM.
    rr_fixed = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_data  = 8'hA0;
    for (int c = 0; c < 16; c++) begin
      @(negedge sys_clk);
      if (cmd_ready) begin
        model_push(cmd_mode, cmd_data);
        acc++;
      end
      @(posedge sys_clk);
      #1;
      cmd_data = 8'hA0 + 8'(acc);
      cmd_mode = 2'(acc);
    end
    check("capacity", 16'(acc), 16'(DEPTH + 1));
    @(negedge sys_clk);
    check("full_ready", {15'h0, cmd_ready}, 16'd0);
    // Release with the host still pushing; pops while full must not admit.
    rr_fixed = 1'b1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      @(negedge sys_clk);
      if (cmd_ready) begin
        model_push(cmd_mode, cmd_data);
        acc++;
      end
      @(posedge sys_clk);
      #1;
      cmd_data = 8'hC0 + 8'(acc);
      cmd_mode = 2'(acc + 2);
    end
    cmd_valid = 1'b0;
    wait_drain();

    // Random mixed commands with random backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_cmd(2'($urandom_range(0, 3)), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      #1;
    end
    wait_drain();
    rr_rand = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;

    // Reset while a command is in DRIVE and another is queued.
    push_cmd(2'd0, 8'h33);
    push_cmd(2'd1, 8'h44);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge sys_clk);
      if (tile_bus != 8'h00) seen = 1;
    end
    check("drive_seen", {15'h0, seen}, 16'd1);
    #1 sys_rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(posedge sys_clk);
    #1;
    check("rst_drive_bus",   {8'h0, tile_bus},   16'h00);
    check("rst_drive_busy",  {15'h0, busy},      16'd0);
    check("rst_drive_valid", {15'h0, rsp_valid}, 16'd0);
    sys_rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (rsp_valid || busy) stray = 1;
    end
    check("no_rsp_after_rst", {15'h0, stray}, 16'd0);
    @(posedge sys_clk);
    #1;
    push_cmd(2'd0, 8'h77);
    wait_drain();

    // Pointer wrap: 3*DEPTH commands one at a time.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      push_cmd(2'($urandom_range(0, 3)), 8'($urandom));
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
